// File: rtl/bit_serializer_if.sv
// Handshake and serial-output bundle for bit_serializer.
// The producer/monitor side uses the master modport; the serializer uses slave.
interface bit_serializer_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] data_in;
   logic             load_valid;
   logic             load_ready;
   logic             out_bit;
   logic             out_valid;
   logic             out_last;
   logic [15:0]      word_cnt;

   modport master (
      output data_in,
      output load_valid,
      input  load_ready,
      input  out_bit,
      input  out_valid,
      input  out_last,
      input  word_cnt
   );

   modport slave (
      input  data_in,
      input  load_valid,
      output load_ready,
      output out_bit,
      output out_valid,
      output out_last,
      output word_cnt
   );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clock out.
// Define BIT_SERIALIZER_LSB_FIRST_EN for LSB-first output; MSB-first otherwise.
module bit_serializer #(
   parameter int unsigned WIDTH = 8
) (
   input logic            clk,
   input logic            reset_n,
   bit_serializer_if.slave bus
);
   localparam int unsigned     CntW   = $clog2(WIDTH);
   localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

   typedef enum logic {
      StIdle,
      StShift
   } state_e;

   state_e           r_state,    w_state_d;
   logic [WIDTH-1:0] r_sreg,     w_sreg_d;
   logic [CntW-1:0]  r_bcnt,     w_bcnt_d;
   logic [15:0]      r_word_cnt, w_word_cnt_d;

   logic             w_shifting;
   logic             w_last;
   logic             w_load_ready;
   logic             w_handshake;
   logic             w_head;
   logic [WIDTH-1:0] w_sreg_shifted;

   assign w_shifting   = (r_state == StShift);
   assign w_last       = w_shifting && (r_bcnt == '0);
   // Ready depends on registered state only, so it never loops back from load_valid.
   assign w_load_ready = (r_state == StIdle) || w_last;
   assign w_handshake  = bus.load_valid && w_load_ready;

`ifdef BIT_SERIALIZER_LSB_FIRST_EN
   assign w_head         = r_sreg[0];
   assign w_sreg_shifted = {1'b0, r_sreg[WIDTH-1:1]};
`else
   assign w_head         = r_sreg[WIDTH-1];
   assign w_sreg_shifted = {r_sreg[WIDTH-2:0], 1'b0};
`endif

   always_comb begin
      w_state_d    = r_state;
      w_sreg_d     = r_sreg;
      w_bcnt_d     = r_bcnt;
      w_word_cnt_d = r_word_cnt;
      unique case (r_state)
         StIdle: begin
            if (w_handshake) begin
               w_sreg_d  = bus.data_in;
               w_bcnt_d  = CntMax;
               w_state_d = StShift;
            end
         end
         StShift: begin
            if (r_bcnt == '0) begin
               w_word_cnt_d = r_word_cnt + 16'd1;
               // A handshake here keeps the stream gapless across the word boundary.
               if (w_handshake) begin
                  w_sreg_d = bus.data_in;
                  w_bcnt_d = CntMax;
               end else begin
                  w_state_d = StIdle;
               end
            end else begin
               w_sreg_d = w_sreg_shifted;
               w_bcnt_d = r_bcnt - CntW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= StIdle;
         r_sreg     <= '0;
         r_bcnt     <= '0;
         r_word_cnt <= '0;
      end else begin
         r_state    <= w_state_d;
         r_sreg     <= w_sreg_d;
         r_bcnt     <= w_bcnt_d;
         r_word_cnt <= w_word_cnt_d;
      end
   end

   assign bus.load_ready = w_load_ready;
   assign bus.out_valid  = w_shifting;
   assign bus.out_bit    = w_shifting && w_head;
   assign bus.out_last   = w_last;
   assign bus.word_cnt   = r_word_cnt;
endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer (WIDTH=8) with a bit-level scoreboard queue.
module tb_bit_serializer;
   logic clk;
   logic reset_n;

   int n_tests = 0;
   int n_fail  = 0;

   bit_serializer_if #(.WIDTH(8)) bus ();

   bit_serializer #(.WIDTH(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef BIT_SERIALIZER_LSB_FIRST_EN
   localparam logic [7:0] ExpB3Stream = 8'hCD;
   localparam logic [7:0] B2bFirst    = 8'h80;
   localparam logic [7:0] B2bSecond   = 8'h01;
`else
   localparam logic [7:0] ExpB3Stream = 8'hB3;
   localparam logic [7:0] B2bFirst    = 8'h01;
   localparam logic [7:0] B2bSecond   = 8'h80;
`endif
   localparam logic [19:0] ResetVec = 20'h80000;

   // Scoreboard entry: {bit, last}, pushed in serial order at the handshake.
   logic [1:0]  sb_q[$];
   logic        e_valid, e_bit, e_last, e_ready;
   logic [15:0] m_cnt;

   function automatic logic [19:0] obs_vec();
      return {bus.load_ready, bus.out_valid, bus.out_bit, bus.out_last, bus.word_cnt};
   endfunction

   function automatic logic [19:0] exp_vec();
      return {e_ready, e_valid, e_bit, e_last, m_cnt};
   endfunction

   task automatic model_reset();
      sb_q.delete();
      m_cnt   = 16'd0;
      e_valid = 1'b0;
      e_bit   = 1'b0;
      e_last  = 1'b0;
      e_ready = 1'b1;
   endtask

   task automatic apply_reset();
      reset_n        = 1'b0;
      bus.load_valid = 1'b0;
      bus.data_in    = 8'h00;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Drives one cycle, then samples the model's expectation for the next cycle at negedge.
   task automatic step(input logic v, input logic [7:0] d, output logic hs);
      bus.load_valid = v;
      bus.data_in    = d;
      hs = v && e_ready;
      if (hs) begin
         for (int i = 0; i < 8; i++) begin
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
            sb_q.push_back({d[i], i == 7});
`else
            sb_q.push_back({d[7-i], i == 7});
`endif
         end
      end
      @(posedge clk);
      if (e_last) m_cnt = m_cnt + 16'd1;
      @(negedge clk);
      if (sb_q.size() > 0) begin
         logic [1:0] ent;
         ent     = sb_q.pop_front();
         e_valid = 1'b1;
         e_bit   = ent[1];
         e_last  = ent[0];
      end else begin
         e_valid = 1'b0;
         e_bit   = 1'b0;
         e_last  = 1'b0;
      end
      e_ready = !e_valid || e_last;
   endtask

   task automatic test_reset();
      logic hs;
      #1;
      n_tests++;
      if (obs_vec() !== ResetVec) begin
         n_fail++;
         $display("FAIL reset_async got=%05h exp=%05h", obs_vec(), ResetVec);
      end
      apply_reset();
      for (int c = 0; c < 20; c++) begin
         step(1'b0, 8'hA5, hs);
         n_tests++;
         if (obs_vec() !== ResetVec) begin
            n_fail++;
            $display("FAIL idle cyc=%0d got=%05h exp=%05h", c, obs_vec(), ResetVec);
         end
      end
   endtask

   task automatic test_single_word();
      logic       hs;
      logic [7:0] stream;
      stream = 8'h00;
      step(1'b1, 8'hB3, hs);
      for (int c = 0; c < 9; c++) begin
         n_tests++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL single cyc=%0d got=%05h exp=%05h", c, obs_vec(), exp_vec());
         end
         if (bus.out_valid) stream = {stream[6:0], bus.out_bit};
         step(1'b0, 8'h00, hs);
      end
      n_tests++;
      if (stream !== ExpB3Stream) begin
         n_fail++;
         $display("FAIL single_stream got=%02h exp=%02h", stream, ExpB3Stream);
      end
   endtask

   task automatic test_back_to_back();
      logic        hs;
      int          n_hs;
      int          rises;
      logic [15:0] stream;
      stream = 16'h0;
      n_hs   = 0;
      step(1'b1, B2bFirst, hs);
      if (hs) n_hs++;
      for (int c = 0; c < 17; c++) begin
         n_tests++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL b2b cyc=%0d got=%05h exp=%05h", c, obs_vec(), exp_vec());
         end
         if (bus.out_valid) stream = {stream[14:0], bus.out_bit};
         step(n_hs < 2, B2bSecond, hs);
         if (hs) n_hs++;
      end
      n_tests++;
      if (stream !== 16'h0180) begin
         n_fail++;
         $display("FAIL b2b_stream got=%04h exp=0180", stream);
      end
      rises = 0;
      for (int i = 0; i < 15; i++) if (stream[i] && stream[i+1]) rises++;
      n_tests++;
      if (rises !== 1) begin
         n_fail++;
         $display("FAIL b2b_detector_rises got=%0d exp=1", rises);
      end
   endtask

   task automatic test_backpressure();
      logic        hs;
      logic        want;
      int          seen;
      logic [15:0] stream;
      stream = 16'h0;
      seen   = 0;
      want   = 1'b0;
      step(1'b1, 8'h5A, hs);
      for (int c = 0; c < 17; c++) begin
         n_tests++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL backpressure cyc=%0d got=%05h exp=%05h", c, obs_vec(), exp_vec());
         end
         if (bus.out_valid) begin
            stream = {stream[14:0], bus.out_bit};
            seen++;
         end
         if (seen == 4) want = 1'b1;
         step(want, 8'hFF, hs);
         if (hs) begin
            want = 1'b0;
            n_tests++;
            if (seen !== 8) begin
               n_fail++;
               $display("FAIL backpressure_accept_at got=%0d exp=8", seen);
            end
         end
      end
      n_tests++;
      if (stream !== 16'h5AFF) begin
         n_fail++;
         $display("FAIL backpressure_stream got=%04h exp=5aff", stream);
      end
   endtask

   task automatic test_async_reset();
      logic       hs;
      logic [7:0] stream;
      apply_reset();
      step(1'b1, 8'hB3, hs);
      for (int c = 0; c < 3; c++) step(1'b0, 8'h00, hs);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL arst_pre got=%05h exp=%05h", obs_vec(), exp_vec());
      end
      #1 reset_n = 1'b0;
      #1;
      n_tests++;
      if (obs_vec() !== ResetVec) begin
         n_fail++;
         $display("FAIL arst_immediate got=%05h exp=%05h", obs_vec(), ResetVec);
      end
      model_reset();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      step(1'b0, 8'h00, hs);
      n_tests++;
      if (obs_vec() !== ResetVec) begin
         n_fail++;
         $display("FAIL arst_after got=%05h exp=%05h", obs_vec(), ResetVec);
      end
      stream = 8'h00;
      step(1'b1, 8'hB3, hs);
      for (int c = 0; c < 9; c++) begin
         n_tests++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL arst_word cyc=%0d got=%05h exp=%05h", c, obs_vec(), exp_vec());
         end
         if (bus.out_valid) stream = {stream[6:0], bus.out_bit};
         step(1'b0, 8'h00, hs);
      end
      n_tests++;
      if (stream !== ExpB3Stream || bus.word_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL arst_word_result got=%02h/%0d exp=%02h/1", stream, bus.word_cnt,
                  ExpB3Stream);
      end
   endtask

   initial begin
      reset_n        = 1'b0;
      bus.load_valid = 1'b0;
      bus.data_in    = 8'h00;
      model_reset();
      test_reset();
      test_single_word();
      test_back_to_back();
      test_backpressure();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
